// File: rtl/sqrt_iter_unit.sv
// Sequential integer square root using a restoring digit recurrence.
// Each CALC cycle takes 2*BITS_PER_CYCLE radicand bits, MSB first, and
// resolves BITS_PER_CYCLE root bits. The results are asqrt = floor(sqrt(a))
// and rem = a - asqrt^2. Valid/ready handshakes are used on both sides.
module sqrt_iter_unit #(
    parameter int WIDTH          = 128,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] asqrt,
    output logic [WIDTH/2:0]   rem,
    output logic               busy
);
    localparam int HW    = WIDTH / 2;
    localparam int ITERS = HW / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int SH    = 2 * BITS_PER_CYCLE;
    // The working remainder is shifted before the trial subtract. A partial
    // remainder stays below 2^(HW+2), so one extra bit holds the sign.
    localparam int RW    = HW + 3;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_last;
    logic [WIDTH-1:0] r_rad;
    logic [HW-1:0]   r_root;
    logic [HW+1:0]   r_rem;
    logic [CW-1:0]   r_cnt;
    logic [HW-1:0]   r_asqrt;
    logic [HW:0]     r_rem_out;
    logic [HW-1:0]   w_root;
    logic [RW-1:0]   w_rem;
    logic [RW-1:0]   w_trial;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic, plus the accept and last-iteration strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: if (in_valid) begin
                w_next   = S_CALC;
                w_accept = 1'b1;
            end
            S_CALC: if (r_cnt == '0) begin
                w_next = S_DONE;
                w_last = 1'b1;
            end
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One cycle of the recurrence: BITS_PER_CYCLE restoring trial-subtracts in series
    always_comb begin
        w_root  = r_root;
        w_rem   = {1'b0, r_rem};
        w_trial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_rem   = {w_rem[RW-3:0], r_rad[WIDTH-1-2*k -: 2]};
            w_trial = w_rem - {1'b0, w_root, 2'b01};
            if (!w_trial[RW-1]) begin
                w_rem  = w_trial;
                w_root = {w_root[HW-2:0], 1'b1};
            end else begin
                w_root = {w_root[HW-2:0], 1'b0};
            end
        end
    end

    // Datapath: capture on accept, iterate in CALC, latch results on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad     <= '0;
            r_root    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_asqrt   <= '0;
            r_rem_out <= '0;
        end else if (w_accept) begin
            r_rad  <= a;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= CW'(ITERS - 1);
        end else if (r_state == S_CALC) begin
            r_rad  <= r_rad << SH;
            r_root <= w_root;
            r_rem  <= w_rem[HW+1:0];
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_asqrt   <= w_root;
                r_rem_out <= w_rem[HW:0];
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign asqrt     = r_asqrt;
    assign rem       = r_rem_out;

endmodule
